sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the external Ram1 SRAM. It grants the SRAM to either the serial loader (port A) or the CPU data path (port B) using round-robin priority. It then runs a fixed setup/strobe/hold cycle on the active-low Ram1 control pins and returns read data with a one-cycle acknowledge. It sits between the serial/CPU logic and the board-level Ram1 pins and is the only driver of those pins.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_arbiter_if.sv | 31 +++
 rtl/sram_rr_pick.sv | 23 ++
 rtl/sram_arbiter.sv | 119 +++++++++++
 tb/tb_sram_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared constants for the Ram1 arbiter: FSM encodings, port selects and
// strobe-length limits.
package sram_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    typedef logic port_sel_t;
    localparam port_sel_t PORT_A = 1'b0;
    localparam port_sel_t PORT_B = 1'b1;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    function automatic port_sel_t rr_other(input port_sel_t sel);
        return ~sel;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for the two Ram1 client ports (serial loader = A, CPU = B).
interface sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_ack, a_rdata, b_ack, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_ack, a_rdata, b_ack, b_rdata
    );
endinterface

// File: rtl/sram_rr_pick.sv
// Combinational two-way round-robin choice; on contention the port that
// did not win last time is picked.
module sram_rr_pick
    import sram_pkg::*;
(
    input  logic      a_req,
    input  logic      b_req,
    input  port_sel_t last_grant,
    output logic      grant_valid,
    output port_sel_t grant_sel
);

    always_comb begin
        grant_valid = a_req | b_req;
        if (a_req && b_req)
            grant_sel = rr_other(last_grant);
        else if (a_req)
            grant_sel = PORT_A;
        else
            grant_sel = PORT_B;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Ram1 SRAM arbiter and access sequencer: round-robin grant, then a fixed
// setup/strobe/hold cycle on the active-low pins with a one-cycle ack.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    sram_arbiter_if.slave     bus,
    output logic              busy,
    output logic [ADDR_W-1:0] Ram1Addr,
    inout  wire  [DATA_W-1:0] Ram1Data,
    output logic              Ram1OE,
    output logic              Ram1WE,
    output logic              Ram1EN
);

    if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
        $error("sram_arbiter: WAIT_CYCLES=%0d outside %0d..%0d", WAIT_CYCLES, WAIT_MIN, WAIT_MAX);
    end

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    port_sel_t         sel_reg, last_grant_reg;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              drive_reg, en_reg, oe_reg, wen_reg;
    logic              grant_valid, grant, last_strobe;
    port_sel_t         grant_sel;

    sram_rr_pick u_pick (
        .a_req       (bus.a_req),
        .b_req       (bus.b_req),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    assign grant       = (state_reg == ST_IDLE) && grant_valid;
    assign last_strobe = (state_reg == ST_STROBE) && (cnt_reg == CNT_W'(WAIT_CYCLES - 1));
    assign we_next     = grant ? ((grant_sel == PORT_A) ? bus.a_we : bus.b_we) : we_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (grant_valid) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: if (last_strobe) state_next = ST_HOLD;
            ST_HOLD:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Pin levels are decoded from the next state so every control pin and the
    // data-drive enable come straight out of a flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            sel_reg        <= PORT_B;
            last_grant_reg <= PORT_B;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            drive_reg      <= 1'b0;
            en_reg         <= 1'b1;
            oe_reg         <= 1'b1;
            wen_reg        <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= (state_reg == ST_STROBE && !last_strobe) ? cnt_reg + 1'b1 : '0;
            we_reg    <= we_next;
            if (grant) begin
                sel_reg        <= grant_sel;
                last_grant_reg <= grant_sel;
                addr_reg       <= (grant_sel == PORT_A) ? bus.a_addr  : bus.b_addr;
                wdata_reg      <= (grant_sel == PORT_A) ? bus.a_wdata : bus.b_wdata;
            end
            en_reg    <= (state_next == ST_IDLE);
            wen_reg   <= !(we_next && state_next == ST_STROBE);
            oe_reg    <= !(!we_next && (state_next == ST_SETUP || state_next == ST_STROBE));
            drive_reg <= we_next && (state_next != ST_IDLE);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              ack_reg;
        logic [DATA_W-1:0] rdata_reg;

        // Read data is captured on the edge leaving the final strobe cycle.
        always_ff @(posedge CLK) begin
            if (RST) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg <= last_strobe && (sel_reg == port_sel_t'(gi));
                if (last_strobe && !we_reg && (sel_reg == port_sel_t'(gi)))
                    rdata_reg <= Ram1Data;
            end
        end
    end

    assign bus.a_ack   = g_port[0].ack_reg;
    assign bus.a_rdata = g_port[0].rdata_reg;
    assign bus.b_ack   = g_port[1].ack_reg;
    assign bus.b_rdata = g_port[1].rdata_reg;

    assign busy     = (state_reg != ST_IDLE);
    assign Ram1Addr = addr_reg;
    assign Ram1EN   = en_reg;
    assign Ram1OE   = oe_reg;
    assign Ram1WE   = wen_reg;
    assign Ram1Data = drive_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with a 1-cycle strobe and a
// behavioural SRAM, one with a 3-cycle strobe and a scripted data source.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus1();
    sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus2();

    logic        busy1, busy2;
    logic [17:0] addr1, addr2;
    wire  [15:0] data1, data2;
    logic        oe1, we1, en1, oe2, we2, en2;

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
        .CLK(clk), .RST(rst), .bus(bus1), .busy(busy1), .Ram1Addr(addr1),
        .Ram1Data(data1), .Ram1OE(oe1), .Ram1WE(we1), .Ram1EN(en1)
    );

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(3)) dut2 (
        .CLK(clk), .RST(rst), .bus(bus2), .busy(busy2), .Ram1Addr(addr2),
        .Ram1Data(data2), .Ram1OE(oe2), .Ram1WE(we2), .Ram1EN(en2)
    );

    // Undriven bus reads as all-ones so a released data bus is observable.
    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
        pullup (data1[gi]);
        pullup (data2[gi]);
    end

    logic [15:0] mem [0:31];
    logic [15:0] d2;
    assign data1 = (!oe1 && !en1) ? mem[addr1[4:0]] : 16'hzzzz;
    assign data2 = (!oe2 && !en2) ? d2 : 16'hzzzz;

    always @(posedge clk) begin
        if (!we1 && !en1)
            mem[addr1[4:0]] <= data1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        d2  = 16'h0000;
        bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = '0; bus1.a_wdata = '0;
        bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = '0; bus1.b_wdata = '0;
        bus2.a_req = 0; bus2.a_we = 0; bus2.a_addr = '0; bus2.a_wdata = '0;
        bus2.b_req = 0; bus2.b_we = 0; bus2.b_addr = '0; bus2.b_wdata = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_ctl",   {29'd0, en1, oe1, we1}, 32'h7);
        check("rst_busy",  {31'd0, busy1}, 32'd0);
        check("rst_ack",   {30'd0, bus1.a_ack, bus1.b_ack}, 32'd0);
        check("rst_rdata", {bus1.a_rdata, bus1.b_rdata}, 32'd0);
        check("rst_addr",  {14'd0, addr1}, 32'd0);
        check("rst_data",  {16'd0, data1}, 32'h0000ffff);
        rst = 1'b0;

        // Port A write 0x1234 -> 0x00010
        bus1.a_we = 1; bus1.a_addr = 18'h00010; bus1.a_wdata = 16'h1234; bus1.a_req = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("wr_en_c%0d", k),   {31'd0, en1}, (k <= 3) ? 32'd0 : 32'd1);
            check($sformatf("wr_we_c%0d", k),   {31'd0, we1}, (k == 2) ? 32'd0 : 32'd1);
            check($sformatf("wr_oe_c%0d", k),   {31'd0, oe1}, 32'd1);
            check($sformatf("wr_data_c%0d", k), {16'd0, data1}, (k <= 3) ? 32'h1234 : 32'hffff);
            check($sformatf("wr_ack_c%0d", k),  {30'd0, bus1.a_ack, bus1.b_ack}, (k == 3) ? 32'd2 : 32'd0);
            if (k == 3) bus1.a_req = 0;
        end
        check("wr_busy_idle", {31'd0, busy1}, 32'd0);
        $display("txn A write addr=00010 data=1234");

        // Port B read from 0x00010
        bus1.b_we = 0; bus1.b_addr = 18'h00010; bus1.b_req = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("rd_oe_c%0d", k),   {31'd0, oe1}, (k <= 2) ? 32'd0 : 32'd1);
            check($sformatf("rd_en_c%0d", k),   {31'd0, en1}, (k <= 3) ? 32'd0 : 32'd1);
            check($sformatf("rd_data_c%0d", k), {16'd0, data1}, (k <= 2) ? 32'h1234 : 32'hffff);
            check($sformatf("rd_ack_c%0d", k),  {30'd0, bus1.a_ack, bus1.b_ack}, (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("rd_brd_c%0d", k),  {16'd0, bus1.b_rdata}, (k >= 3) ? 32'h1234 : 32'd0);
            check($sformatf("rd_ard_c%0d", k),  {16'd0, bus1.a_rdata}, 32'd0);
            if (k == 3) bus1.b_req = 0;
        end
        $display("txn B read addr=00010 rdata=%h", bus1.b_rdata);

        // Contention: A, B, A, B on a 4-cycle period
        bus1.a_we = 0; bus1.a_addr = 18'h00003; bus1.b_we = 0; bus1.b_addr = 18'h00005;
        bus1.a_req = 1; bus1.b_req = 1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("rr_ack_c%0d", k), {30'd0, bus1.a_ack, bus1.b_ack},
                  (k % 8 == 3) ? 32'd2 : ((k % 8 == 7) ? 32'd1 : 32'd0));
            if (k % 4 == 1)
                check($sformatf("rr_addr_c%0d", k), {14'd0, addr1}, (k % 8 == 1) ? 32'h3 : 32'h5);
            if (k % 4 == 3)
                $display("txn rr grant=%s", bus1.a_ack ? "A" : "B");
            if (k == 15) begin bus1.a_req = 0; bus1.b_req = 0; end
        end

        // WAIT_CYCLES=3 read, data changes during strobe
        bus2.a_we = 0; bus2.a_addr = 18'h00007; bus2.a_req = 1; d2 = 16'h1111;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("w3_oe_c%0d", k),  {31'd0, oe2}, (k <= 4) ? 32'd0 : 32'd1);
            check($sformatf("w3_ack_c%0d", k), {30'd0, bus2.a_ack, bus2.b_ack}, (k == 5) ? 32'd2 : 32'd0);
            check($sformatf("w3_rd_c%0d", k),  {16'd0, bus2.a_rdata}, (k >= 5) ? 32'h4444 : 32'd0);
            check($sformatf("w3_busy_c%0d", k), {31'd0, busy2}, (k <= 5) ? 32'd1 : 32'd0);
            if (k == 2) d2 = 16'h2222;
            if (k == 3) d2 = 16'h3333;
            if (k == 4) d2 = 16'h4444;
            if (k == 5) bus2.a_req = 0;
        end
        $display("txn A(w3) read addr=00007 rdata=%h", bus2.a_rdata);

        // Reset during the strobe of a write
        bus1.a_we = 1; bus1.a_addr = 18'h0001f; bus1.a_wdata = 16'hbeef; bus1.a_req = 1;
        @(negedge clk);
        check("rs_en_setup", {31'd0, en1}, 32'd0);
        @(negedge clk);
        check("rs_we_strobe", {31'd0, we1}, 32'd0);
        rst = 1'b1; bus1.a_req = 0;
        @(negedge clk);
        check("rs_ctl",   {29'd0, en1, oe1, we1}, 32'h7);
        check("rs_data",  {16'd0, data1}, 32'h0000ffff);
        check("rs_busy",  {31'd0, busy1}, 32'd0);
        check("rs_ack",   {30'd0, bus1.a_ack, bus1.b_ack}, 32'd0);
        check("rs_brd",   {16'd0, bus1.b_rdata}, 32'd0);
        rst = 1'b0;
        $display("txn A write aborted by reset");

        bus1.a_we = 0; bus1.a_addr = 18'h00001; bus1.b_we = 0; bus1.b_addr = 18'h00002;
        bus1.a_req = 1; bus1.b_req = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) check("rs_first_addr", {14'd0, addr1}, 32'h1);
            check($sformatf("rs_ack_c%0d", k), {30'd0, bus1.a_ack, bus1.b_ack}, (k == 3) ? 32'd2 : 32'd0);
            if (k == 3) begin bus1.a_req = 0; bus1.b_req = 0; end
        end
        $display("txn post-reset contention granted A");

        // Request dropped during SETUP still completes
        bus1.a_we = 1; bus1.a_addr = 18'h00002; bus1.a_wdata = 16'h00aa; bus1.a_req = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus1.a_req = 0;
            check($sformatf("dr_ack_c%0d", k),  {30'd0, bus1.a_ack, bus1.b_ack}, (k == 3) ? 32'd2 : 32'd0);
            check($sformatf("dr_busy_c%0d", k), {31'd0, busy1}, (k <= 3) ? 32'd1 : 32'd0);
        end
        $display("txn A write with early req drop addr=00002");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
